// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions: FSM/op encodings and the default modulus constants.
package rsa_pkg;
    localparam int N_BIT_DEF = 7;
    localparam int E_BIT_DEF = 8;
    localparam int LOGR_DEF  = 3;
    localparam logic [N_BIT_DEF-1:0] N_DEF      = 7'd79;
    localparam logic [LOGR_DEF-1:0]  P_DEF      = 3'd1;
    localparam logic [N_BIT_DEF-1:0] R2MODN_DEF = 7'd22;

    typedef enum logic [2:0] {ST_IDLE, ST_SCAN, ST_RUN, ST_REL, ST_NEXT, ST_DONE} state_t;
    typedef enum logic {OP_SQR, OP_MUL} op_t;
    typedef enum logic [1:0] {MM_IDLE, MM_CALC, MM_DONE} mm_state_t;
endpackage

// File: rtl/mod_exp_if.sv
// Start/done handshake and operand/result bus of the modular exponentiator.
interface mod_exp_if
    import rsa_pkg::*;
#(
    parameter int N_BIT = N_BIT_DEF,
    parameter int E_BIT = E_BIT_DEF
);
    logic             start;
    logic [N_BIT-1:0] m;
    logic [E_BIT-1:0] e;
    logic [N_BIT-1:0] c;
    logic             busy;
    logic             done;

    modport master (output start, m, e, input c, busy, done);
    modport slave  (input start, m, e, output c, busy, done);
endinterface

// File: rtl/mod_mul.sv
// Digit-serial Montgomery multiplier returning z = x*y mod n (two Montgomery passes:
// x*y*R^-1, then *R^2*R^-1). done stays high while start stays high.
module mod_mul
    import rsa_pkg::*;
#(
    parameter int                N_BIT  = N_BIT_DEF,
    parameter logic [N_BIT-1:0]  N      = N_DEF,
    parameter int                LOGR   = LOGR_DEF,
    parameter logic [LOGR-1:0]   P      = P_DEF,
    parameter logic [N_BIT-1:0]  R2MODN = R2MODN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_BIT-1:0] x,
    input  logic [N_BIT-1:0] y,
    output logic [N_BIT-1:0] z,
    output logic             done
);
    localparam int K  = (N_BIT + LOGR - 1) / LOGR;
    localparam int AW = K * LOGR;
    localparam int TW = N_BIT + LOGR + 2;   // partial sum stays below 2n + 2*R*n
    localparam int CW = $clog2(K) + 1;

    mm_state_t        state_reg, state_next;
    logic             pass_reg, pass_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [AW-1:0]    a_reg, a_next;
    logic [N_BIT-1:0] b_reg, b_next;
    logic [TW-1:0]    t_reg, t_next;
    logic [N_BIT-1:0] z_reg, z_next;
    logic             done_reg, done_next;

    logic [TW-1:0]    sum, red;
    logic [LOGR-1:0]  q;
    logic [N_BIT-1:0] fin;

    always_comb begin
        sum = t_reg + TW'(a_reg[LOGR-1:0]) * TW'(b_reg);
        q   = sum[LOGR-1:0] * P;
        red = (sum + TW'(q) * TW'(N)) >> LOGR;
        fin = (t_reg >= TW'(N)) ? N_BIT'(t_reg - TW'(N)) : N_BIT'(t_reg);
    end

    always_comb begin
        state_next = state_reg;
        pass_next  = pass_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        t_next     = t_reg;
        z_next     = z_reg;
        done_next  = done_reg;
        case (state_reg)
            MM_IDLE: begin
                done_next = 1'b0;
                if (start) begin
                    a_next     = AW'(x);
                    b_next     = y;
                    t_next     = '0;
                    cnt_next   = '0;
                    pass_next  = 1'b0;
                    state_next = MM_CALC;
                end
            end
            MM_CALC: begin
                if (cnt_reg == CW'(K)) begin
                    cnt_next = '0;
                    t_next   = '0;
                    if (!pass_reg) begin
                        a_next    = AW'(fin);
                        b_next    = R2MODN;
                        pass_next = 1'b1;
                    end else begin
                        z_next     = fin;
                        done_next  = 1'b1;
                        state_next = MM_DONE;
                    end
                end else begin
                    t_next   = red;
                    a_next   = a_reg >> LOGR;
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            MM_DONE: begin
                if (!start) begin
                    done_next  = 1'b0;
                    state_next = MM_IDLE;
                end
            end
            default: state_next = MM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= MM_IDLE;
            pass_reg  <= 1'b0;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            t_reg     <= '0;
            z_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pass_reg  <= pass_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            t_reg     <= t_next;
            z_reg     <= z_next;
            done_reg  <= done_next;
        end
    end

    assign z    = z_reg;
    assign done = done_reg;
endmodule

// File: rtl/mod_exp.sv
// Modular exponentiator c = m^e mod n using left-to-right square-and-multiply,
// one mod_mul transaction per square and per multiply.
module mod_exp
    import rsa_pkg::*;
#(
    parameter logic [N_BIT_DEF-1:0] N      = N_DEF,
    parameter int                   N_BIT  = N_BIT_DEF,
    parameter int                   E_BIT  = E_BIT_DEF,
    parameter int                   LOGR   = LOGR_DEF,
    parameter logic [LOGR-1:0]      P      = P_DEF,
    parameter logic [N_BIT-1:0]     R2MODN = R2MODN_DEF
) (
    input  logic     clk,
    input  logic     rst,
    mod_exp_if.slave bus
);
    localparam int IW = $clog2(E_BIT);

    state_t           state_reg, state_next;
    op_t              op_reg, op_next;
    logic [N_BIT-1:0] m_r_reg, m_r_next;
    logic [E_BIT-1:0] e_r_reg, e_r_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic [N_BIT-1:0] acc_reg, acc_next;
    logic [N_BIT-1:0] mm_x_reg, mm_x_next, mm_y_reg, mm_y_next;
    logic             mm_start_reg, mm_start_next;
    logic [N_BIT-1:0] c_reg, c_next;
    logic             busy_reg, busy_next, done_reg, done_next;
    logic [N_BIT-1:0] mm_z;
    logic             mm_done;

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        m_r_next      = m_r_reg;
        e_r_next      = e_r_reg;
        idx_next      = idx_reg;
        acc_next      = acc_reg;
        mm_x_next     = mm_x_reg;
        mm_y_next     = mm_y_reg;
        mm_start_next = mm_start_reg;
        c_next        = c_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    m_r_next   = bus.m;
                    e_r_next   = bus.e;
                    idx_next   = IW'(E_BIT - 1);
                    busy_next  = 1'b1;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (e_r_reg == '0) begin
                    acc_next   = N_BIT'(1);
                    state_next = ST_DONE;
                end else if (e_r_reg[idx_reg]) begin
                    acc_next = m_r_reg;
                    if (idx_reg == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx_reg - IW'(1);
                        op_next    = OP_SQR;
                        state_next = ST_RUN;
                    end
                end else begin
                    idx_next = idx_reg - IW'(1);
                end
            end
            ST_RUN: begin
                if (mm_done) begin
                    acc_next      = mm_z;
                    mm_start_next = 1'b0;
                    state_next    = ST_REL;
                end
            end
            // mod_mul holds done while start is high; wait for it to fall
            ST_REL: begin
                if (!mm_done) state_next = ST_NEXT;
            end
            ST_NEXT: begin
                if (op_reg == OP_SQR && e_r_reg[idx_reg]) begin
                    op_next    = OP_MUL;
                    state_next = ST_RUN;
                end else if (idx_reg == '0) begin
                    state_next = ST_DONE;
                end else begin
                    idx_next   = idx_reg - IW'(1);
                    op_next    = OP_SQR;
                    state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                c_next     = acc_reg;
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // Operands are loaded once on entry to RUN and held for the whole transaction
        if (state_next == ST_RUN && state_reg != ST_RUN) begin
            mm_start_next = 1'b1;
            mm_x_next     = acc_next;
            mm_y_next     = (op_next == OP_SQR) ? acc_next : m_r_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            op_reg       <= OP_SQR;
            m_r_reg      <= '0;
            e_r_reg      <= '0;
            idx_reg      <= '0;
            acc_reg      <= '0;
            mm_x_reg     <= '0;
            mm_y_reg     <= '0;
            mm_start_reg <= 1'b0;
            c_reg        <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            m_r_reg      <= m_r_next;
            e_r_reg      <= e_r_next;
            idx_reg      <= idx_next;
            acc_reg      <= acc_next;
            mm_x_reg     <= mm_x_next;
            mm_y_reg     <= mm_y_next;
            mm_start_reg <= mm_start_next;
            c_reg        <= c_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    mod_mul #(
        .N_BIT  (N_BIT),
        .N      (N_BIT'(N)),
        .LOGR   (LOGR),
        .P      (P),
        .R2MODN (R2MODN)
    ) inst_mod_mul (
        .clk   (clk),
        .rst_n (~rst),
        .start (mm_start_reg),
        .x     (mm_x_reg),
        .y     (mm_y_reg),
        .z     (mm_z),
        .done  (mm_done)
    );

    assign bus.c    = c_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
endmodule

// File: tb/tb_mod_exp.sv
// Directed and randomized checks of mod_exp against a repeated-multiplication modpow model.
module tb_mod_exp;
    import rsa_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mod_exp_if #(.N_BIT(7), .E_BIT(8)) bus ();

    mod_exp #(
        .N(7'd79), .N_BIT(7), .E_BIT(8), .LOGR(3), .P(3'd1), .R2MODN(7'd22)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int modpow(input int b, input int x);
        int r = 1;
        for (int i = 0; i < x; i++) r = (r * b) % 79;
        return r;
    endfunction

    // One exponentiation; optionally pulses a second start intr_at cycles into the run.
    task automatic run_op(input int mi, input int ei, input int intr_at,
                          output int c_o, output int dones, output int starts,
                          output int busy_first);
        int   post;
        bit   seen;
        logic prev_mm;
        dones = 0; starts = 0; c_o = -1; seen = 0; post = 0; prev_mm = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.m = 7'(mi); bus.e = 8'(ei);
        @(negedge clk);
        bus.start = 1'b0; bus.m = 7'($urandom); bus.e = 8'($urandom);
        busy_first = int'(bus.busy);
        for (int cyc = 0; cyc < 4000 && post < 4; cyc++) begin
            if (cyc == intr_at) begin
                bus.start = 1'b1;
                bus.m = 7'($urandom_range(0, 78));
                bus.e = 8'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            if (dut.mm_start_reg && !prev_mm) starts++;
            prev_mm = dut.mm_start_reg;
            if (bus.done) begin
                dones++;
                if (!seen) c_o = int'(bus.c);
                seen = 1'b1;
            end
            if (seen) post++;
            @(negedge clk);
        end
        check("timeout", 32'(seen), 1);
        check("busy_after", 32'(bus.busy), 0);
        $display("txn m=%0d e=%0d c=%0d model=%0d dones=%0d mm_starts=%0d",
                 mi, ei, c_o, modpow(mi, ei), dones, starts);
    endtask

    initial begin
        int c_got, dn, st, bf, mi, ei;
        bit reached;
        rst = 1'b1; bus.start = 1'b0; bus.m = '0; bus.e = '0;
        repeat (3) @(negedge clk);
        check("rst_c", 32'(bus.c), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_mm_start", 32'(dut.mm_start_reg), 0);
        rst = 1'b0;

        run_op(5, 3, -1, c_got, dn, st, bf);
        check("t1_c", c_got, 46);
        check("t1_dones", dn, 1);
        check("t1_busy", bf, 1);

        run_op(33, 0, -1, c_got, dn, st, bf);
        check("t2_e0_c", c_got, 1);
        check("t2_e0_mm", st, 0);
        run_op(17, 1, -1, c_got, dn, st, bf);
        check("t2_e1_c", c_got, 17);
        check("t2_e1_mm", st, 0);

        run_op(2, 255, -1, c_got, dn, st, bf);
        check("t3_c", c_got, 18);
        check("t3_mm_starts", st, 14);

        run_op(78, 2, -1, c_got, dn, st, bf);
        check("t4_m78_c", c_got, 1);
        run_op(0, 5, -1, c_got, dn, st, bf);
        check("t4_m0_c", c_got, 0);

        run_op(2, 255, 5, c_got, dn, st, bf);
        check("t5_c", c_got, 18);
        check("t5_dones", dn, 1);

        @(negedge clk);
        bus.start = 1'b1; bus.m = 7'd2; bus.e = 8'd255;
        @(negedge clk);
        bus.start = 1'b0;
        reached = 1'b0;
        for (int cyc = 0; cyc < 200 && !reached; cyc++) begin
            if (dut.state_reg == ST_RUN) reached = 1'b1;
            else @(negedge clk);
        end
        check("t6_reach_run", 32'(reached), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_busy", 32'(bus.busy), 0);
        check("t6_done", 32'(bus.done), 0);
        check("t6_c", 32'(bus.c), 0);
        rst = 1'b0;
        run_op(5, 3, -1, c_got, dn, st, bf);
        check("t6_after_c", c_got, 46);

        for (int k = 0; k < 200; k++) begin
            mi = int'($urandom_range(0, 78));
            ei = int'($urandom_range(0, 255));
            run_op(mi, ei, -1, c_got, dn, st, bf);
            check("rand_c", c_got, modpow(mi, ei));
            check("rand_dones", dn, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
